// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared constants for the instruction prefetcher: RV32I NOP encoding, default reset PC and
// the base instruction width.
package fetch_prefetch_unit_pkg;

   localparam int unsigned INST_W           = 32;
   localparam logic [31:0] RV32I_NOP        = 32'h0000_0013;
   localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_prefetch_unit_fifo.sv
// Synchronous first-word-fall-through FIFO with synchronous clear; holds {pc, inst} pairs.
module fetch_prefetch_unit_fifo
   import fetch_prefetch_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 2 * INST_W,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_clear,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_data,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_data    = r_mem[r_rptr];
   // A push into a full queue is only legal when the head leaves in the same cycle.
   assign w_do_push = i_push && !i_clear && (!o_full || i_pop);
   assign w_do_pop  = i_pop && !o_empty && !i_clear;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_do_push && !i_rst) begin
         r_mem[r_wptr] <= i_data;
      end
   end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction prefetcher: pipelined program-memory requests with credit-limited issue, an
// FWFT queue towards decode, and redirect handling that drops stale in-flight responses.
module fetch_prefetch_unit
   import fetch_prefetch_unit_pkg::*;
#(
   parameter int unsigned    XLEN            = INST_W,
   parameter int unsigned    DEPTH           = 4,
   parameter int unsigned    MAX_OUTSTANDING = 2,
   parameter logic [XLEN-1:0] PC_RESET       = XLEN'(PC_RESET_DEFAULT)
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_branch_sig,
   input  logic [XLEN-1:0] i_branch_pc,
   input  logic            i_stall,
   output logic            o_mem_req,
   output logic [XLEN-1:0] o_mem_addr,
   input  logic            i_mem_gnt,
   input  logic            i_mem_ack,
   input  logic [XLEN-1:0] i_mem_data,
   output logic            o_valid,
   output logic [XLEN-1:0] o_inst,
   output logic [XLEN-1:0] o_pc
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned SW = CW + 1;

   logic [XLEN-1:0]   r_fetch_pc;
   logic [XLEN-1:0]   r_resp_pc;
   logic [CW-1:0]     r_out;
   logic [CW-1:0]     r_drop;

   logic [CW-1:0]     w_count;
   logic              w_full;
   logic              w_empty;
   logic [2*XLEN-1:0] w_head;
   logic [SW-1:0]     w_inflight;
   logic [SW-1:0]     w_credit_used;
   logic              w_issue;
   logic              w_ack_any;
   logic              w_ack_drop;
   logic              w_ack_keep;
   logic              w_push;
   logic              w_pop;
   logic [XLEN-1:0]   w_target;
   logic              w_unused_pc_lsbs;

   assign w_inflight    = SW'(r_out) + SW'(r_drop);
   assign w_credit_used = SW'(w_count) + SW'(r_out);
   assign o_mem_req     = !i_rst && !i_branch_sig
                          && (w_inflight < SW'(MAX_OUTSTANDING))
                          && (w_credit_used < SW'(DEPTH));
   assign o_mem_addr    = r_fetch_pc;
   assign w_issue       = o_mem_req && i_mem_gnt;

   // Dropped responses are always the oldest ones, so they are consumed before live ones.
   assign w_ack_any     = i_mem_ack && (w_inflight != '0);
   assign w_ack_drop    = w_ack_any && (r_drop != '0);
   assign w_ack_keep    = w_ack_any && (r_drop == '0);
   assign w_push        = w_ack_keep && !i_branch_sig;
   assign w_pop         = !w_empty && !i_stall;

   assign w_target         = {i_branch_pc[XLEN-1:2], 2'b00};
   assign w_unused_pc_lsbs = ^i_branch_pc[1:0];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_fetch_pc <= PC_RESET;
         r_resp_pc  <= PC_RESET;
         r_out      <= '0;
         r_drop     <= '0;
      end else if (i_branch_sig) begin
         r_fetch_pc <= w_target;
         r_resp_pc  <= w_target;
         r_out      <= '0;
         // Everything still in flight after this cycle's ack becomes stale.
         r_drop     <= r_drop + r_out - CW'(w_ack_any);
      end else begin
         if (w_issue) begin
            r_fetch_pc <= r_fetch_pc + XLEN'(4);
         end
         if (w_push) begin
            r_resp_pc <= r_resp_pc + XLEN'(4);
         end
         r_out  <= r_out + CW'(w_issue) - CW'(w_ack_keep);
         r_drop <= r_drop - CW'(w_ack_drop);
      end
   end

   fetch_prefetch_unit_fifo #(
      .WIDTH (2 * XLEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clear (i_branch_sig),
      .i_push  (w_push),
      .i_data  ({r_resp_pc, i_mem_data}),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign o_valid = !w_empty;
   assign o_inst  = o_valid ? w_head[XLEN-1:0] : XLEN'(RV32I_NOP);
   assign o_pc    = o_valid ? w_head[2*XLEN-1:XLEN] : '0;

   a_ack_has_owner: assert property (@(posedge i_clk) disable iff (i_rst)
      !(i_mem_ack && (w_inflight == '0)));
   a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
      !(w_push && w_full && !w_pop));
   a_counters_bounded: assert property (@(posedge i_clk) disable iff (i_rst)
      (SW'(w_count) <= SW'(DEPTH)) && (SW'(r_out) <= SW'(DEPTH))
      && (SW'(r_drop) <= SW'(DEPTH)));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomised and directed bench for fetch_prefetch_unit against a queue-based reference model.
module tb_fetch_prefetch_unit;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned MAXO   = 2;
   localparam logic [31:0] PC_RST = 32'h0;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk;
   logic        i_rst;
   logic        i_branch_sig;
   logic [31:0] i_branch_pc;
   logic        i_stall;
   logic        o_mem_req;
   logic [31:0] o_mem_addr;
   logic        i_mem_gnt;
   logic        i_mem_ack;
   logic [31:0] i_mem_data;
   logic        o_valid;
   logic [31:0] o_inst;
   logic [31:0] o_pc;

   fetch_prefetch_unit #(
      .XLEN            (32),
      .DEPTH           (DEPTH),
      .MAX_OUTSTANDING (MAXO),
      .PC_RESET        (PC_RST)
   ) dut (
      .i_clk        (clk),
      .i_rst        (i_rst),
      .i_branch_sig (i_branch_sig),
      .i_branch_pc  (i_branch_pc),
      .i_stall      (i_stall),
      .o_mem_req    (o_mem_req),
      .o_mem_addr   (o_mem_addr),
      .i_mem_gnt    (i_mem_gnt),
      .i_mem_ack    (i_mem_ack),
      .i_mem_data   (i_mem_data),
      .o_valid      (o_valid),
      .o_inst       (o_inst),
      .o_pc         (o_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: delivered PCs, in-flight requests (address + stale flag), next fetch PC.
   logic [31:0] buf_q[$];
   logic [31:0] fl_addr[$];
   bit          fl_stale[$];
   logic [31:0] m_fetch_pc;

   int          n_checks;
   int          n_fail;
   logic        exp_req;
   logic        exp_valid;
   logic [31:0] exp_pc;
   logic [31:0] exp_inst;
   logic [97:0] obs_vec;
   logic [97:0] exp_vec;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
   endfunction

   function automatic int live_count();
      int n = 0;
      foreach (fl_stale[k]) if (!fl_stale[k]) n++;
      return n;
   endfunction

   // Drives one cycle, computes the expected outputs, then advances the model.
   task automatic step(input bit rst, input bit br, input logic [31:0] bpc, input bit stall,
                       input bit gnt, input bit ack_en);
      bit          do_ack;
      logic [31:0] a;
      bit          s;
      @(negedge clk);
      do_ack       = ack_en && !rst && (fl_addr.size() > 0);
      i_rst        = rst;
      i_branch_sig = br;
      i_branch_pc  = bpc;
      i_stall      = stall;
      i_mem_gnt    = gnt;
      i_mem_ack    = do_ack;
      i_mem_data   = do_ack ? inst_of(fl_addr[0]) : $urandom;
      #1;
      exp_req   = !rst && !br && (fl_addr.size() < MAXO) && (buf_q.size() + live_count() < DEPTH);
      exp_valid = (buf_q.size() != 0);
      exp_pc    = exp_valid ? buf_q[0] : 32'h0;
      exp_inst  = exp_valid ? inst_of(buf_q[0]) : NOP;
      exp_vec   = {exp_req, m_fetch_pc, exp_valid, exp_pc, exp_inst};
      obs_vec   = {o_mem_req, o_mem_addr, o_valid, o_pc, o_inst};
      if (rst) begin
         buf_q.delete();
         fl_addr.delete();
         fl_stale.delete();
         m_fetch_pc = PC_RST;
      end else begin
         if (exp_valid && !stall) void'(buf_q.pop_front());
         if (do_ack) begin
            a = fl_addr.pop_front();
            s = fl_stale.pop_front();
            if (!s && !br) buf_q.push_back(a);
         end
         if (exp_req && gnt) begin
            fl_addr.push_back(m_fetch_pc);
            fl_stale.push_back(1'b0);
            m_fetch_pc = m_fetch_pc + 32'd4;
         end
         if (br) begin
            buf_q.delete();
            foreach (fl_stale[k]) fl_stale[k] = 1'b1;
            m_fetch_pc = {bpc[31:2], 2'b00};
         end
      end
   endtask

   task automatic do_reset();
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (o_mem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_req_low: got %b want 0", o_mem_req);
      end
      step(0, 0, 0, 0, 0, 0);
      n_checks++;
      if (o_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_valid: got %b want 0", o_valid);
      end
      n_checks++;
      if (o_inst !== NOP) begin
         n_fail++;
         $display("FAIL reset_inst: got %h want %h", o_inst, NOP);
      end
      n_checks++;
      if (o_pc !== 32'h0 || o_mem_addr !== PC_RST) begin
         n_fail++;
         $display("FAIL reset_pc_addr: got pc %h addr %h want 0 / %h", o_pc, o_mem_addr, PC_RST);
      end
      n_checks++;
      if (o_mem_req !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_first_req: got %b want 1", o_mem_req);
      end
   endtask

   task automatic test_stream();
      do_reset();
      for (int i = 0; i < 24; i++) begin
         step(0, 0, 0, 0, 1, 1);
         n_checks++;
         if (obs_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL stream c%0d: got %h want %h", i, obs_vec, exp_vec);
         end
         if (i >= 2) begin
            n_checks++;
            if (o_valid !== 1'b1 || o_pc !== 32'(4 * (i - 2))) begin
               n_fail++;
               $display("FAIL stream_seq c%0d: got v%b pc %h want v1 pc %h", i, o_valid, o_pc,
                        32'(4 * (i - 2)));
            end
         end
      end
   endtask

   task automatic test_stall();
      logic [31:0] frozen;
      logic [31:0] next_pc;
      do_reset();
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 1);
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 0, 1, 1, 1);
         if (i == 0) frozen = exp_pc;
         n_checks++;
         if (obs_vec !== exp_vec || o_pc !== frozen) begin
            n_fail++;
            $display("FAIL stall c%0d: got %h want %h (frozen pc %h)", i, obs_vec, exp_vec, frozen);
         end
      end
      n_checks++;
      if (o_mem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_credit_req: got %b want 0", o_mem_req);
      end
      next_pc = frozen;
      for (int i = 0; i < 12; i++) begin
         step(0, 0, 0, 0, 1, 1);
         n_checks++;
         if (obs_vec !== exp_vec || (o_valid === 1'b1 && o_pc !== next_pc)) begin
            n_fail++;
            $display("FAIL stall_resume c%0d: got %h want %h (next pc %h)", i, obs_vec, exp_vec,
                     next_pc);
         end
         if (o_valid === 1'b1) next_pc = next_pc + 32'd4;
      end
   endtask

   task automatic test_redirect();
      logic [31:0] got[$];
      do_reset();
      step(0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 1, 0, 1);
      step(0, 0, 0, 1, 1, 1);
      step(0, 0, 0, 1, 1, 0);
      step(0, 1, 32'h0000_0103, 0, 1, 0);
      n_checks++;
      if (obs_vec !== exp_vec || o_mem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL redirect_cycle: got %h want %h", obs_vec, exp_vec);
      end
      for (int i = 0; i < 20 && got.size() < 2; i++) begin
         step(0, 0, 0, 0, 1, 1);
         n_checks++;
         if (obs_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL redirect_follow c%0d: got %h want %h", i, obs_vec, exp_vec);
         end
         if (o_valid === 1'b1) got.push_back(o_pc);
      end
      n_checks++;
      if (got.size() < 2) begin
         n_fail++;
         $display("FAIL redirect_timeout: got %0d valid words want 2", got.size());
      end else if (got[0] !== 32'h100 || got[1] !== 32'h104) begin
         n_fail++;
         $display("FAIL redirect_target: got %h,%h want 00000100,00000104", got[0], got[1]);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 1);
      step(0, 1, 32'h0000_0200, 0, 1, 1);
      n_checks++;
      if (obs_vec !== exp_vec) begin
         n_fail++;
         $display("FAIL b2b_first: got %h want %h", obs_vec, exp_vec);
      end
      step(0, 1, 32'h0000_0302, 0, 1, 1);
      n_checks++;
      if (obs_vec !== exp_vec || o_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_second: got %h want %h", obs_vec, exp_vec);
      end
      for (int i = 0; i < 12; i++) begin
         step(0, 0, 0, 0, 1, 1);
         n_checks++;
         if (obs_vec !== exp_vec
             || (o_valid === 1'b1 && (o_pc < 32'h300 || o_pc >= 32'h400))) begin
            n_fail++;
            $display("FAIL b2b_no_stale c%0d: got %h want %h", i, obs_vec, exp_vec);
         end
      end
   endtask

   task automatic test_wrap();
      logic [31:0] got[$];
      do_reset();
      step(0, 0, 0, 0, 1, 1);
      step(0, 1, 32'hFFFF_FFF9, 0, 1, 1);
      for (int i = 0; i < 20 && got.size() < 3; i++) begin
         step(0, 0, 0, 0, 1, 1);
         n_checks++;
         if (obs_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL wrap_follow c%0d: got %h want %h", i, obs_vec, exp_vec);
         end
         if (o_valid === 1'b1) got.push_back(o_pc);
      end
      n_checks++;
      if (got.size() < 3) begin
         n_fail++;
         $display("FAIL wrap_timeout: got %0d valid words want 3", got.size());
      end else if (got[0] !== 32'hFFFF_FFF8 || got[1] !== 32'hFFFF_FFFC || got[2] !== 32'h0) begin
         n_fail++;
         $display("FAIL wrap_seq: got %h,%h,%h want fffffff8,fffffffc,00000000",
                  got[0], got[1], got[2]);
      end
   endtask

   task automatic test_reset_midway();
      do_reset();
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 1);
      step(0, 0, 0, 1, 1, 0);
      step(1, 0, 0, 1, 1, 1);
      step(0, 0, 0, 0, 0, 0);
      n_checks++;
      if (o_valid !== 1'b0 || o_inst !== NOP || o_mem_addr !== PC_RST || o_pc !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_midway: got v%b inst %h addr %h pc %h want v0 %h %h 0",
                  o_valid, o_inst, o_mem_addr, o_pc, NOP, PC_RST);
      end
      n_checks++;
      if (obs_vec !== exp_vec) begin
         n_fail++;
         $display("FAIL reset_midway_model: got %h want %h", obs_vec, exp_vec);
      end
   endtask

   task automatic test_random();
      bit rst;
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         rst = ($urandom_range(0, 399) == 0);
         step(rst, ($urandom_range(0, 99) < 4), $urandom, ($urandom_range(0, 99) < 30),
              ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 60));
         if (!rst) begin
            n_checks++;
            if (obs_vec !== exp_vec) begin
               n_fail++;
               $display("FAIL random c%0d: got %h want %h", i, obs_vec, exp_vec);
            end
         end
      end
   endtask

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      i_rst        = 1'b1;
      i_branch_sig = 1'b0;
      i_branch_pc  = '0;
      i_stall      = 1'b0;
      i_mem_gnt    = 1'b0;
      i_mem_ack    = 1'b0;
      i_mem_data   = '0;
      m_fetch_pc   = PC_RST;
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_back_to_back();
      test_wrap();
      test_reset_midway();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
